// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sitting beside the execute stage.
// One shared 34-bit add/subtract datapath serves all eight M-extension ops:
// radix-2 shift-add for multiplies, restoring division for div/rem.
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            DD_md_valid_i,
  input  logic [2:0]      DD_md_op_i,
  input  logic [XLEN-1:0] DD_rs1_data_i,
  input  logic [XLEN-1:0] DD_rs2_data_i,
  input  logic            E_flush_i,
  output logic            M_stall_o,
  output logic            M_valid_o,
  output logic [XLEN-1:0] M_result_o,
  output logic            M_busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             spec_q;
  logic [XLEN-1:0]  hi_q, lo_q, opnd_q, res_q;

  logic             start;
  logic             is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic             div_zero, div_ovf, special;
  logic [XLEN-1:0]  a_abs, b_abs, spec_res;

  logic [XLEN+1:0]  alu_a, alu_b, alu_y;
  logic [XLEN-1:0]  hi_nxt, lo_nxt;

  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   quot_n, rem_n, final_res;

  assign start = DD_md_valid_i & ~E_flush_i & (state_q == IDLE);

  // Decode the incoming op: operand signedness, magnitudes, result sign and the division special cases
  always_comb begin
    is_div   = DD_md_op_i[2];
    a_signed = (DD_md_op_i == 3'd1) | (DD_md_op_i == 3'd2) |
               (DD_md_op_i == 3'd4) | (DD_md_op_i == 3'd6);
    b_signed = (DD_md_op_i == 3'd1) | (DD_md_op_i == 3'd4) | (DD_md_op_i == 3'd6);
    a_neg    = a_signed & DD_rs1_data_i[XLEN-1];
    b_neg    = b_signed & DD_rs2_data_i[XLEN-1];
    a_abs    = a_neg ? (~DD_rs1_data_i + 1'b1) : DD_rs1_data_i;
    b_abs    = b_neg ? (~DD_rs2_data_i + 1'b1) : DD_rs2_data_i;
    neg_in   = (is_div & DD_md_op_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div & (DD_rs2_data_i == '0);
    div_ovf  = ((DD_md_op_i == 3'd4) | (DD_md_op_i == 3'd6)) &
               (DD_rs1_data_i == MIN_INT) & (DD_rs2_data_i == ALL_ONES);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      spec_res = DD_md_op_i[1] ? DD_rs1_data_i : ALL_ONES;
    end else begin
      spec_res = DD_md_op_i[1] ? '0 : MIN_INT;
    end
  end

  // Shared iteration datapath: add for multiply, trial subtract for divide
  always_comb begin
    alu_b = {2'b00, opnd_q};
    if (op_q[2]) begin
      alu_a = {1'b0, hi_q, lo_q[XLEN-1]};
      alu_y = alu_a - alu_b;
      if (!alu_y[XLEN+1]) begin
        hi_nxt = alu_y[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = alu_a[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      alu_a = {2'b00, hi_q};
      alu_y = alu_a + alu_b;
      if (lo_q[0]) begin
        hi_nxt = alu_y[XLEN:1];
        lo_nxt = {alu_y[0], lo_q[XLEN-1:1]};
      end else begin
        hi_nxt = {1'b0, hi_q[XLEN-1:1]};
        lo_nxt = {hi_q[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Sign-correct and select the final result from the accumulator
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_n = neg_q ? (~prod + 1'b1) : prod;
    quot_n = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_n  = neg_q ? (~hi_q + 1'b1) : hi_q;
    if (spec_q) begin
      final_res = lo_q;
    end else if (op_q == 3'd0) begin
      final_res = prod_n[XLEN-1:0];
    end else if (!op_q[2]) begin
      final_res = prod_n[2*XLEN-1:XLEN];
    end else if (op_q[1]) begin
      final_res = rem_n;
    end else begin
      final_res = quot_n;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; flush wins over start and completion
  always_comb begin
    state_d   = state_q;
    M_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (E_flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        M_valid_o = ~E_flush_i;
      end
      default: state_d = IDLE;
    endcase
    M_stall_o  = start | (state_q == BUSY);
    M_busy_o   = (state_q != IDLE);
    M_result_o = M_valid_o ? final_res : res_q;
  end

  // Working registers: load operands on accept, iterate in BUSY, keep the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      res_q  <= '0;
    end else begin
      if (start) begin
        op_q   <= DD_md_op_i;
        cnt_q  <= '0;
        hi_q   <= '0;
        spec_q <= special;
        if (special) begin
          neg_q  <= 1'b0;
          lo_q   <= spec_res;
          opnd_q <= '0;
        end else if (is_div) begin
          neg_q  <= neg_in;
          lo_q   <= a_abs;
          opnd_q <= b_abs;
        end else begin
          neg_q  <= neg_in;
          lo_q   <= b_abs;
          opnd_q <= a_abs;
        end
      end else if (state_q == BUSY) begin
        if (E_flush_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
        end
      end
      if (M_valid_o) begin
        res_q <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: the driver pushes expected results and
// completion cycles, a negedge monitor pops and compares on every valid pulse.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DD_md_valid_i = 1'b0;
  logic [2:0]  DD_md_op_i = '0;
  logic [31:0] DD_rs1_data_i = '0;
  logic [31:0] DD_rs2_data_i = '0;
  logic        E_flush_i = 1'b0;
  logic        M_stall_o, M_valid_o, M_busy_o;
  logic [31:0] M_result_o;

  typedef struct {
    logic [31:0] val;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   valid_last = -1;
  int   valid_prev = -1;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .DD_md_valid_i (DD_md_valid_i),
    .DD_md_op_i    (DD_md_op_i),
    .DD_rs1_data_i (DD_rs1_data_i),
    .DD_rs2_data_i (DD_rs2_data_i),
    .E_flush_i     (E_flush_i),
    .M_stall_o     (M_stall_o),
    .M_valid_o     (M_valid_o),
    .M_result_o    (M_result_o),
    .M_busy_o      (M_busy_o)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected entry, in value and in cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && M_valid_o) begin
      valid_prev = valid_last;
      valid_last = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid actual=0x%08h required=no_valid at cycle %0d", M_result_o, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_result"}, M_result_o, e.val);
        checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  // Present one op in DD and hold it until it retires at the end of DONE
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_val, input bit spec);
    int n;
    int lat;
    lat = spec ? 1 : 33;
    @(negedge clk);
    DD_md_op_i    = op;
    DD_rs1_data_i = a;
    DD_rs2_data_i = b;
    DD_md_valid_i = 1'b1;
    sb.push_back('{val: exp_val, at: cyc + lat, name: name});
    #1;
    n = 0;
    while (M_stall_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput({name, "_stall_cycles"}, 32'(n), 32'(lat));
    checkOutput({name, "_busy_in_done"}, {31'd0, M_busy_o}, 32'd1);
  endtask

  task automatic dropValid();
    @(negedge clk);
    DD_md_valid_i = 1'b0;
  endtask

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    int waited;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_stall", {31'd0, M_stall_o}, 32'd0);
    checkOutput("reset_valid", {31'd0, M_valid_o}, 32'd0);
    checkOutput("reset_busy",  {31'd0, M_busy_o},  32'd0);
    checkOutput("reset_result", M_result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("mul_7_m3",      3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    applyStimulus("mulh_min_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    applyStimulus("mulhu_ff_ff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    applyStimulus("mulhsu_ff_ff",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    applyStimulus("div_m7_2",      3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
    applyStimulus("rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
    applyStimulus("divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       1'b0);
    applyStimulus("remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
    applyStimulus("div_5_0",       3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    applyStimulus("rem_5_0",       3'd6, 32'd5,        32'd0,        32'd5,        1'b1);
    applyStimulus("remu_big_0",    3'd7, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b1);
    applyStimulus("div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    applyStimulus("rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    dropValid();

    // Flush while BUSY with counter at 10: no result, back to IDLE next cycle
    @(negedge clk);
    DD_md_op_i    = 3'd5;
    DD_rs1_data_i = 32'd1000;
    DD_rs2_data_i = 32'd7;
    DD_md_valid_i = 1'b1;
    repeat (11) @(negedge clk);
    checkOutput("flush_busy_before", {31'd0, M_busy_o}, 32'd1);
    E_flush_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_idle_busy",  {31'd0, M_busy_o},  32'd0);
    checkOutput("flush_idle_stall", {31'd0, M_stall_o}, 32'd0);
    @(negedge clk);
    E_flush_i     = 1'b0;
    DD_md_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 1'b0);
    dropValid();

    // Asynchronous reset in the middle of an op
    @(negedge clk);
    DD_md_op_i    = 3'd0;
    DD_rs1_data_i = 32'd5;
    DD_rs2_data_i = 32'd6;
    DD_md_valid_i = 1'b1;
    repeat (6) @(negedge clk);
    DD_md_valid_i = 1'b0;
    rst_n         = 1'b0;
    #1;
    checkOutput("midreset_stall", {31'd0, M_stall_o}, 32'd0);
    checkOutput("midreset_valid", {31'd0, M_valid_o}, 32'd0);
    checkOutput("midreset_busy",  {31'd0, M_busy_o},  32'd0);
    checkOutput("midreset_result", M_result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back multiplies: completions exactly 34 cycles apart
    applyStimulus("mul_b2b_a", 3'd0, 32'd12345,    32'd100,      32'h0012D644, 1'b0);
    applyStimulus("mul_b2b_b", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    dropValid();
    checkOutput("b2b_spacing", 32'(valid_last - valid_prev), 32'd34);

    waited = 0;
    while (sb.size() > 0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
